multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Control FSM for the multicycle RV32I datapath: the core shares one unified memory port, one ALU and one result bus across the phases of each instruction. This block sequences that datapath from the latched instruction fields and the ALU zero flag. It drives every mux select, write enable and ALU operation per phase, and stalls on a memory-ready handshake. It supports lw, sw, R-type ALU, I-type ALU, beq and jal.

## Interface
- No parameters; all encodings come from the shared package.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- op  in  7  Instr[6:0] from instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register / OldPC enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  operand A select: 00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  operand B select: 00 RD2, 01 ImmExt, 10 const 4
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal  out  1  one-cycle pulse when Decode sees an unsupported opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0, else goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target).
  - lw 0000011 and sw 0100011 → MEMADR.
  - 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL.
  - Any other opcode → FETCH with illegal=1 and instr_done=1.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. op[5]=0 → MEMREAD, else → MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, → FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Holds until mem_ready=1, then → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, funct decode, → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, funct decode, → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, → ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero, → FETCH.
- Funct decode (ALUOp=10):
  - funct3 000 → sub if op[5]&funct7b5, else add.
  - 010 → slt; 110 → or; 111 → and; any other funct3 → add.
- ImmSrc is combinational from op in every state: sw 01, beq 10, jal 11, all others 00.
- instr_done is asserted in MEMWB, ALUWB, BEQ, the illegal DECODE cycle, and in MEMWRITE when mem_ready=1.
- Unused selects are driven 00, never X.

## Timing
- While reset=0:
  - State is FETCH.
  - PCWrite, IRWrite, RegWrite, MemWrite, instr_done and illegal are all 0.
  - Selects take their FETCH values.
- Leaving reset: the first active edge after deassertion evaluates the FETCH transition.
- Outputs are Moore decodes of state, with these exceptions, which are Mealy:
  - PCWrite depends on mem_ready in FETCH and on zero in BEQ.
  - IRWrite depends on mem_ready in FETCH.
  - instr_done depends on mem_ready in MEMWRITE.
- Latency with mem_ready=1 throughout, in cycles: lw 5; sw, R, I, jal 4; beq 3; illegal 2.
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
  - All outputs are held during the stall.
  - MemWrite stays high across the whole MEMWRITE stall.
- Reset asserted mid-instruction: state goes immediately to FETCH and all enables go to 0 in the same cycle. No partial register or memory write completes after assertion.

## Structure
- Package riscv_ctrl_pkg holds:
  - 4-bit state encoding constants;
  - opcode constants;
  - ALUOp, ALUControl, ImmSrc, ResultSrc and ALUSrcA/B codes.
- Sub-module mc_aludec: combinational ALUOp/funct3/funct7b5/op[5] → ALUControl.
- Top level: state register plus next-state logic and output decode.

## Test plan
- lw, mem_ready=1: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - RegWrite=1 only in cycle 5, with ResultSrc=01.
  - instr_done pulses in cycle 5.
- sw with mem_ready low for the first 2 MEMWRITE cycles:
  - MemWrite=1, AdrSrc=1 for 3 consecutive cycles.
  - ImmSrc=01; then FETCH.
- beq (op 1100011):
  - zero=1 → PCWrite=1 in BEQ with ALUControl=001.
  - zero=0 → PCWrite=0; 3 cycles total either way.
- ALU decode:
  - R-type funct3=000, funct7b5=1 → ALUControl=001 in EXECR.
  - addi with funct7b5=1 → 000.
  - funct3=111 → 010.
- op=0000000: illegal and instr_done pulse in DECODE, with no RegWrite/MemWrite/PCWrite; next state FETCH.
- reset driven low during MEMREAD of a lw with mem_ready=0:
  - All enables are 0 immediately.
  - After release, FETCH with IRWrite=1 on the first mem_ready=1.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: states, opcodes,
// ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU operation decode: maps ALUOp plus the instruction funct fields to an
// ALUControl code.
module mc_aludec
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only means sub for R-type; addi reuses that bit as immediate.
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM sequencing the shared-resource multicycle RV32I datapath
// (lw, sw, R/I-type ALU, beq, jal) with memory-ready stalls.
//
// state    | meaning
// FETCH    | read instr at PC, PC+4 -> PC when memory ready
// DECODE   | compute branch/jump target, dispatch on opcode
// MEMADR   | rs1 + imm -> ALUOut
// MEMREAD  | read data at ALUOut, wait for memory
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to ALUOut address, wait for memory
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | write ALUOut to rd
// BEQ      | compare rs1 - rs2, take branch on zero
// JAL      | OldPC + 4 -> ALUOut, target -> PC
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal
);

  state_t state_q, state_d;
  logic [1:0] alu_op;
  logic pc_write, mem_write, ir_write, reg_write, done, ill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    alu_op    = ALUOP_ADD;
    pc_write  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    done      = 1'b0;
    ill       = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    case (state_q)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default: begin
            state_d = FETCH;
            ill     = 1'b1;
            done    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        done      = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      EXECR: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = FETCH;
      end
      JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pc_write = 1'b1;
        state_d  = ALUWB;
      end
      BEQ: begin
        ALUSrcA  = SRCA_RD1;
        alu_op   = ALUOP_SUB;
        pc_write = zero;
        done     = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  mc_aludec u_aludec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

  assign ImmSrc = imm_src_of(op);

  // FETCH enables follow mem_ready, so they must be gated while reset is held.
  assign PCWrite    = reset & pc_write;
  assign IRWrite    = reset & ir_write;
  assign MemWrite   = reset & mem_write;
  assign RegWrite   = reset & reg_write;
  assign instr_done = reset & done;
  assign illegal    = reset & ill;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares all outputs against hand-computed vectors.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       instr_done, illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  // Field order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA
  // ALUSrcB ImmSrc ALUControl instr_done illegal
  task automatic chk(input string tag,
                     input logic pcw, input logic adr, input logic mw,
                     input logic irw, input logic rw, input logic [1:0] res,
                     input logic [1:0] sa, input logic [1:0] sb,
                     input logic [1:0] imm, input logic [2:0] alu,
                     input logic done, input logic ill);
    logic [17:0] obs, exp;
    obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ImmSrc, ALUControl, instr_done, illegal};
    exp = {pcw, adr, mw, irw, rw, res, sa, sb, imm, alu, done, ill};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    #12;
    chk("reset_hold", 0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0);

    // lw, memory always ready
    reset = 1'b1; #1;
    chk("lw_fetch",   1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0);
    next_cycle(); #1;
    chk("lw_decode",  0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0,0);
    next_cycle(); #1;
    chk("lw_memadr",  0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0,0);
    next_cycle(); #1;
    chk("lw_memread", 0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0,0);
    next_cycle(); #1;
    chk("lw_memwb",   0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1,0);

    // sw with two stalled MEMWRITE cycles
    next_cycle(); op = 7'b0100011; #1;
    chk("sw_fetch",   1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0,0);
    next_cycle(); #1;
    chk("sw_decode",  0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0,0);
    next_cycle(); #1;
    chk("sw_memadr",  0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0,0);
    next_cycle(); mem_ready = 1'b0; #1;
    chk("sw_stall1",  0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0,0);
    next_cycle(); #1;
    chk("sw_stall2",  0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0,0);
    next_cycle(); mem_ready = 1'b1; #1;
    chk("sw_done",    0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1,0);

    // FETCH stall, then beq taken
    next_cycle(); mem_ready = 1'b0; op = 7'b1100011; funct3 = 3'b000; #1;
    chk("fetch_stall",0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0,0);
    next_cycle(); mem_ready = 1'b1; #1;
    chk("beq1_fetch", 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0,0);
    next_cycle(); #1;
    chk("beq1_decode",0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0,0);
    next_cycle(); zero = 1'b1; #1;
    chk("beq_taken",  1,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1,0);

    // beq not taken
    next_cycle(); zero = 1'b0; #1;
    chk("beq2_fetch", 1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0,0);
    next_cycle(); next_cycle(); #1;
    chk("beq_ntaken", 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1,0);

    // R-type sub
    next_cycle(); op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; #1;
    chk("r_fetch",    1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0);
    next_cycle(); next_cycle(); #1;
    chk("r_sub",      0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0,0);
    next_cycle(); #1;
    chk("r_aluwb",    0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1,0);

    // addi with funct7b5 set stays add
    next_cycle(); op = 7'b0010011; next_cycle(); next_cycle(); #1;
    chk("addi",       0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0,0);
    next_cycle(); #1;
    chk("i_aluwb",    0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1,0);

    // and, or, slt
    next_cycle(); op = 7'b0110011; funct3 = 3'b111; funct7b5 = 1'b0;
    next_cycle(); next_cycle(); #1;
    chk("r_and",      0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010, 0,0);
    next_cycle();
    next_cycle(); op = 7'b0010011; funct3 = 3'b110;
    next_cycle(); next_cycle(); #1;
    chk("i_or",       0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011, 0,0);
    next_cycle();
    next_cycle(); op = 7'b0110011; funct3 = 3'b010;
    next_cycle(); next_cycle(); #1;
    chk("r_slt",      0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b101, 0,0);
    next_cycle();

    // jal
    next_cycle(); op = 7'b1101111; #1;
    chk("jal_fetch",  1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 0,0);
    next_cycle(); next_cycle(); #1;
    chk("jal_exec",   1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0,0);
    next_cycle(); #1;
    chk("jal_aluwb",  0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1,0);

    // illegal opcode
    next_cycle(); op = 7'b0000000; next_cycle(); #1;
    chk("illegal",    0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1,1);
    next_cycle(); mem_ready = 1'b0; #1;
    chk("ill_next",   0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0);

    // reset asserted while a lw stalls in MEMREAD
    next_cycle(); mem_ready = 1'b1; op = 7'b0000011;
    next_cycle(); next_cycle(); next_cycle(); mem_ready = 1'b0; #1;
    chk("rst_memread",0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0,0);
    reset = 1'b0; #1;
    chk("rst_async",  0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0);
    mem_ready = 1'b1; #1;
    chk("rst_gate",   0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0);
    next_cycle(); reset = 1'b1; mem_ready = 1'b0; #1;
    chk("rel_stall",  0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0);
    next_cycle(); mem_ready = 1'b1; #1;
    chk("rel_fetch",  1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0);
    next_cycle(); #1;
    chk("rel_decode", 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0,0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
